// File: rtl/axis_frame_monitor.sv
// rtl/axis_frame_monitor.sv - AXI-Stream video frame monitor with framing checks, checksum and stall generator
module axis_frame_monitor #(
  parameter int          AXIS_DATA_WIDTH = 64,
  parameter int          AXIS_USER_WIDTH = 4,
  parameter int          CNT_WIDTH       = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       aclk,
  input  logic                       aclk_reset,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  input  logic                       cfg_enable,
  input  logic [CNT_WIDTH-1:0]       cfg_expected_beats,
  input  logic [CNT_WIDTH-1:0]       cfg_expected_lines,
  input  logic [1:0]                 cfg_stall_mode,
  input  logic [3:0]                 cfg_stall_period,
  input  logic                       clr_status,
  output logic [31:0]                frame_count,
  output logic [31:0]                frame_checksum,
  output logic                       err_sof,
  output logic                       err_eol,
  output logic                       err_beats,
  output logic                       err_lines,
  output logic                       irq_error,
  output logic                       busy
);

  localparam int LANES = AXIS_DATA_WIDTH / 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_LINE = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_next;
  logic [CNT_WIDTH-1:0] line_cnt, line_cnt_next;
  logic [31:0]          acc, acc_next;
  logic [31:0]          lane_sum;
  logic [3:0]           err_q, err_new;   // {lines, beats, eol, sof}
  logic                 irq_q;
  logic                 frame_done;
  logic                 line_open;
  logic                 beat;
  logic                 tready_q, tready_next;
  logic [3:0]           stall_cnt;
  logic [15:0]          lfsr, lfsr_next;

  logic sof, eof, sol, eol;
  assign sof = s_axis_tuser[0];
  assign eof = s_axis_tuser[1];
  assign sol = s_axis_tuser[2];
  assign eol = s_axis_tuser[3];

  assign beat = s_axis_tvalid & tready_q & cfg_enable;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + s_axis_tdata[i*32 +: 32];
    end
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    line_cnt_next = line_cnt;
    acc_next      = acc;
    err_new       = '0;
    frame_done    = 1'b0;
    line_open     = 1'b0;
    if (!cfg_enable) begin
      state_next = IDLE;
    end else if (beat) begin
      if ((s_axis_tlast != eol) || (eof && !eol)) err_new[1] = 1'b1;
      // SOF always (re)starts a frame and implies SOL; only outside IDLE is it an error
      if (sof) begin
        if (state != IDLE) err_new[0] = 1'b1;
        line_cnt_next = '0;
        beat_cnt_next = CNT_ONE;
        acc_next      = lane_sum;
        line_open     = 1'b1;
        state_next    = IN_LINE;
      end else begin
        case (state)
          IDLE: err_new[0] = 1'b1;
          IN_LINE: begin
            beat_cnt_next = sat_inc(beat_cnt);
            acc_next      = acc + lane_sum;
            line_open     = 1'b1;
          end
          GAP: begin
            if (sol) begin
              beat_cnt_next = CNT_ONE;
              acc_next      = acc + lane_sum;
              line_open     = 1'b1;
              state_next    = IN_LINE;
            end else begin
              err_new[0] = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
      if (line_open && (eol || eof)) begin
        if (beat_cnt_next != cfg_expected_beats) err_new[2] = 1'b1;
        line_cnt_next = sat_inc(line_cnt_next);
        if (eof) begin
          if (line_cnt_next != cfg_expected_lines) err_new[3] = 1'b1;
          frame_done = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      line_cnt <= '0;
      acc      <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
      line_cnt <= line_cnt_next;
      acc      <= acc_next;
    end
  end

  // A same-cycle error or completed frame wins over clr_status
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      err_q          <= '0;
      irq_q          <= 1'b0;
      frame_count    <= '0;
      frame_checksum <= '0;
    end else begin
      err_q <= clr_status ? err_new : (err_q | err_new);
      irq_q <= |(err_new & ~err_q);
      if (frame_done) begin
        frame_count    <= frame_count + 32'd1;
        frame_checksum <= acc_next;
      end else if (clr_status) begin
        frame_count <= '0;
      end
    end
  end

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    tready_next = 1'b1;
    case (cfg_stall_mode)
      2'b01:   tready_next = !((cfg_stall_period != 4'd0) && (stall_cnt == cfg_stall_period));
      2'b10:   tready_next = (lfsr_next[1:0] != 2'b00);
      default: tready_next = 1'b1;
    endcase
    tready_next = tready_next & cfg_enable;
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      stall_cnt <= '0;
      lfsr      <= LFSR_SEED;
      tready_q  <= 1'b0;
    end else begin
      stall_cnt <= (stall_cnt >= cfg_stall_period) ? 4'd0 : stall_cnt + 4'd1;
      lfsr      <= lfsr_next;
      tready_q  <= tready_next;
    end
  end

  assign s_axis_tready = tready_q;
  assign err_sof       = err_q[0];
  assign err_eol       = err_q[1];
  assign err_beats     = err_q[2];
  assign err_lines     = err_q[3];
  assign irq_error     = irq_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_axis_frame_monitor.sv
// tb/tb_axis_frame_monitor.sv - directed self-checking bench for axis_frame_monitor
module tb_axis_frame_monitor;

  logic        aclk = 1'b0;
  logic        aclk_reset;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic        cfg_enable;
  logic [15:0] cfg_expected_beats;
  logic [15:0] cfg_expected_lines;
  logic [1:0]  cfg_stall_mode;
  logic [3:0]  cfg_stall_period;
  logic        clr_status;
  logic [31:0] frame_count;
  logic [31:0] frame_checksum;
  logic        err_sof, err_eol, err_beats, err_lines;
  logic        irq_error;
  logic        busy;

  logic [3:0]  errs;
  assign errs = {err_lines, err_beats, err_eol, err_sof};

  int          passed = 0;
  int          total  = 0;
  int          irq_cnt = 0;
  int          stall_lows = 0;
  logic [31:0] model_sum;

  axis_frame_monitor dut (
    .aclk               (aclk),
    .aclk_reset         (aclk_reset),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .cfg_enable         (cfg_enable),
    .cfg_expected_beats (cfg_expected_beats),
    .cfg_expected_lines (cfg_expected_lines),
    .cfg_stall_mode     (cfg_stall_mode),
    .cfg_stall_period   (cfg_stall_period),
    .clr_status         (clr_status),
    .frame_count        (frame_count),
    .frame_checksum     (frame_checksum),
    .err_sof            (err_sof),
    .err_eol            (err_eol),
    .err_beats          (err_beats),
    .err_lines          (err_lines),
    .irq_error          (irq_error),
    .busy               (busy)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (irq_error) irq_cnt++;
    if (cfg_enable && !aclk_reset && !s_axis_tready) stall_lows++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] u, input logic l);
    int n;
    n = 0;
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    while (!s_axis_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) check("beat_timeout", 32'd1, 32'd0);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
  endtask

  // Lines of b0/b1/b2 beats; beat index bad_last gets an inverted tlast
  task automatic send_frame(input int nl, input int b0, input int b1, input int b2,
                            input int bad_last, input bit rnd);
    int bl[3];
    int k;
    logic [3:0]  u;
    logic [63:0] d;
    bl = '{b0, b1, b2};
    k = 0;
    model_sum = '0;
    for (int ln = 0; ln < nl; ln++) begin
      for (int b = 0; b < bl[ln]; b++) begin
        d = rnd ? {$urandom(), $urandom()} : {32'd1, 32'd1};
        u[0] = (ln == 0) && (b == 0);
        u[2] = (b == 0);
        u[3] = (b == bl[ln] - 1);
        u[1] = u[3] && (ln == nl - 1);
        model_sum = model_sum + d[31:0] + d[63:32];
        send_beat(d, u, u[3] ^ (k == bad_last));
        k++;
      end
    end
  endtask

  task automatic do_clr();
    @(negedge aclk);
    clr_status = 1'b1;
    @(negedge aclk);
    clr_status = 1'b0;
    @(negedge aclk);
    irq_cnt = 0;
  endtask

  initial begin
    int first_low, second_low, lows, bad;
    aclk_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = '0;
    cfg_enable = 1'b1;
    cfg_expected_beats = 16'd4;
    cfg_expected_lines = 16'd3;
    cfg_stall_mode = 2'b00;
    cfg_stall_period = 4'd0;
    clr_status = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_fcount", frame_count, 32'd0);
    check("rst_cksum", frame_checksum, 32'd0);
    check("rst_errs", {28'd0, errs}, 32'd0);
    check("rst_busy_irq", {30'd0, busy, irq_error}, 32'd0);
    aclk_reset = 1'b0;
    repeat (2) @(negedge aclk);
    irq_cnt = 0;

    // two good 4x3 frames, lane data 1
    send_frame(3, 4, 4, 4, -1, 1'b0);
    send_frame(3, 4, 4, 4, -1, 1'b0);
    @(negedge aclk);
    check("good_fcount", frame_count, 32'd2);
    check("good_cksum", frame_checksum, 32'd24);
    check("good_errs", {28'd0, errs}, 32'd0);
    check("good_busy", {31'd0, busy}, 32'd0);

    // short middle line
    send_frame(3, 4, 3, 4, -1, 1'b0);
    repeat (2) @(negedge aclk);
    check("short_errs", {28'd0, errs}, 32'b0100);
    check("short_irq", irq_cnt, 32'd1);
    check("short_fcount", frame_count, 32'd3);
    check("short_cksum", frame_checksum, 32'd22);
    do_clr();
    check("clr1_errs", {28'd0, errs}, 32'd0);
    check("clr1_fcount", frame_count, 32'd0);

    // single-beat lines
    cfg_expected_beats = 16'd1;
    cfg_expected_lines = 16'd2;
    send_frame(2, 1, 1, 0, -1, 1'b0);
    @(negedge aclk);
    check("single_errs", {28'd0, errs}, 32'd0);
    check("single_cksum", frame_checksum, 32'd4);
    cfg_expected_beats = 16'd4;
    cfg_expected_lines = 16'd3;

    // beat without SOF in IDLE
    send_beat({32'd1, 32'd1}, 4'b0000, 1'b0);
    repeat (2) @(negedge aclk);
    check("nosof_errs", {28'd0, errs}, 32'b0001);
    check("nosof_busy", {31'd0, busy}, 32'd0);
    check("nosof_irq", irq_cnt, 32'd1);
    do_clr();

    // SOF mid-line restarts the frame
    send_beat({32'd1, 32'd1}, 4'b0101, 1'b0);
    send_beat({32'd1, 32'd1}, 4'b0000, 1'b0);
    send_frame(3, 4, 4, 4, -1, 1'b0);
    @(negedge aclk);
    check("midsof_errs", {28'd0, errs}, 32'b0001);
    check("midsof_fcount", frame_count, 32'd1);
    check("midsof_cksum", frame_checksum, 32'd24);
    do_clr();

    // tlast on a non-EOL beat
    send_frame(3, 4, 4, 4, 1, 1'b0);
    repeat (2) @(negedge aclk);
    check("tlast_errs", {28'd0, errs}, 32'b0010);
    check("tlast_irq", irq_cnt, 32'd1);
    check("tlast_fcount", frame_count, 32'd1);
    do_clr();
    check("clr2_errs", {28'd0, errs}, 32'd0);
    check("clr2_fcount", frame_count, 32'd0);

    // periodic stall, period 3
    cfg_stall_mode = 2'b01;
    cfg_stall_period = 4'd3;
    repeat (4) @(negedge aclk);
    lows = 0;
    first_low = -1;
    second_low = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (!s_axis_tready) begin
        lows++;
        if (first_low < 0) first_low = i;
        else if (second_low < 0) second_low = i;
      end
    end
    check("per_lows", lows, 32'd4);
    check("per_gap", second_low - first_low, 32'd4);
    send_frame(3, 4, 4, 4, -1, 1'b0);
    @(negedge aclk);
    check("per_fcount", frame_count, 32'd1);
    check("per_cksum", frame_checksum, 32'd24);
    cfg_stall_period = 4'd0;
    repeat (2) @(negedge aclk);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (!s_axis_tready) lows++;
    end
    check("per0_lows", lows, 32'd0);
    do_clr();

    // pseudo-random stall with random data
    cfg_stall_mode = 2'b10;
    repeat (2) @(negedge aclk);
    stall_lows = 0;
    bad = 0;
    for (int f = 0; f < 60; f++) begin
      send_frame(3, 4, 4, 4, -1, 1'b1);
      @(negedge aclk);
      if (frame_checksum !== model_sum) bad++;
    end
    check("rand_cksum_bad", bad, 32'd0);
    check("rand_last_cksum", frame_checksum, model_sum);
    check("rand_fcount", frame_count, 32'd60);
    check("rand_errs", {28'd0, errs}, 32'd0);
    check("rand_stalled", {31'd0, stall_lows > 0}, 32'd1);

    // reset after 5 beats of a frame
    cfg_stall_mode = 2'b00;
    repeat (2) @(negedge aclk);
    send_beat({32'd1, 32'd1}, 4'b0101, 1'b0);
    send_beat({32'd1, 32'd1}, 4'b0000, 1'b0);
    send_beat({32'd1, 32'd1}, 4'b0000, 1'b0);
    send_beat({32'd1, 32'd1}, 4'b1000, 1'b1);
    send_beat({32'd1, 32'd1}, 4'b0100, 1'b0);
    @(negedge aclk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    aclk_reset = 1'b1;
    repeat (2) @(negedge aclk);
    aclk_reset = 1'b0;
    @(negedge aclk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    irq_cnt = 0;
    send_frame(3, 4, 4, 4, -1, 1'b0);
    repeat (2) @(negedge aclk);
    check("mid_fcount", frame_count, 32'd1);
    check("mid_errs", {28'd0, errs}, 32'd0);
    check("mid_cksum", frame_checksum, 32'd24);
    check("mid_irq", irq_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
